perceptron_param_loader: RTL

PERCEPTRON_PARAM_LOADER -- requirements
Module: perceptron_param_loader

---
 rtl/perceptron_pkg.sv | 37 +++
 rtl/perceptron_param_loader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/perceptron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perceptron_pkg
// Description : Shared types and constants for the perceptron parameter loader.
// Revision    : 1.0 - initial release
// ============================================================================
package perceptron_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         NUM_PARAMS     = 10;
    localparam logic [7:0] WEIGHT_MAX     = 8'd7;

    localparam logic [3:0] IDX_IN0       = 4'd0;
    localparam logic [3:0] IDX_IN1       = 4'd1;
    localparam logic [3:0] IDX_IN2       = 4'd2;
    localparam logic [3:0] IDX_IN3       = 4'd3;
    localparam logic [3:0] IDX_WEIGHT0   = 4'd4;
    localparam logic [3:0] IDX_WEIGHT1   = 4'd5;
    localparam logic [3:0] IDX_WEIGHT2   = 4'd6;
    localparam logic [3:0] IDX_WEIGHT3   = 4'd7;
    localparam logic [3:0] IDX_BIAS      = 4'd8;
    localparam logic [3:0] IDX_THRESHOLD = 4'd9;

    // Shift amounts above WEIGHT_MAX would overflow the datapath shifter.
    function automatic logic [7:0] clamp_weight(input logic [7:0] w);
        return (w > WEIGHT_MAX) ? WEIGHT_MAX : w;
    endfunction

endpackage : perceptron_pkg
`default_nettype wire

// File: rtl/perceptron_param_loader.sv
`default_nettype none
// ============================================================================
// Module      : perceptron_param_loader
// Description : Parses checksummed byte frames into a shadow buffer and
//               commits all perceptron parameters atomically.
// Revision    : 1.0 - initial release
// ============================================================================
module perceptron_param_loader
    import perceptron_pkg::*;
#(
    parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_sof,
    output logic       s_ready,
    output logic [7:0] in0,
    output logic [7:0] in1,
    output logic [7:0] in2,
    output logic [7:0] in3,
    output logic [7:0] weight0,
    output logic [7:0] weight1,
    output logic [7:0] weight2,
    output logic [7:0] weight3,
    output logic [7:0] bias,
    output logic [7:0] threshold,
    output logic       cfg_valid,
    output logic       cfg_update,
    output logic       frame_err
);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_index;
    logic [7:0] r_acc;
    logic [7:0] r_shadow [0:NUM_PARAMS-1];

    logic w_accept;
    logic w_start;
    logic w_load;
    logic w_commit;
    logic w_err;

    assign s_ready  = (r_state != HOLD);
    assign w_accept = s_valid && s_ready;

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && s_sof) begin
                    if (s_data == HEADER) begin
                        w_start      = 1'b1;
                        w_state_next = PAYLOAD;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            PAYLOAD, CHECK: begin
                if (w_accept) begin
                    if (s_sof) begin
                        // Abort the frame; the SOF byte is reparsed as a header.
                        w_err = 1'b1;
                        if (s_data == HEADER) begin
                            w_start      = 1'b1;
                            w_state_next = PAYLOAD;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else if (r_state == PAYLOAD) begin
                        w_load = 1'b1;
                        if (r_index == IDX_THRESHOLD) begin
                            w_state_next = CHECK;
                        end
                    end else if (s_data == r_acc) begin
                        w_commit     = 1'b1;
                        w_state_next = HOLD;
                    end else begin
                        w_err        = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            HOLD: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_index <= 4'd0;
            r_acc   <= 8'd0;
            for (int i = 0; i < NUM_PARAMS; i++) begin
                r_shadow[i] <= 8'd0;
            end
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_index <= 4'd0;
                r_acc   <= 8'd0;
            end else if (w_load) begin
                r_shadow[r_index] <= s_data;
                r_acc             <= r_acc ^ s_data;
                r_index           <= r_index + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in0        <= 8'd0;
            in1        <= 8'd0;
            in2        <= 8'd0;
            in3        <= 8'd0;
            weight0    <= 8'd0;
            weight1    <= 8'd0;
            weight2    <= 8'd0;
            weight3    <= 8'd0;
            bias       <= 8'd0;
            threshold  <= 8'd0;
            cfg_valid  <= 1'b0;
            cfg_update <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cfg_update <= w_commit;
            frame_err  <= w_err;
            if (w_commit) begin
                in0       <= r_shadow[IDX_IN0];
                in1       <= r_shadow[IDX_IN1];
                in2       <= r_shadow[IDX_IN2];
                in3       <= r_shadow[IDX_IN3];
                weight0   <= clamp_weight(r_shadow[IDX_WEIGHT0]);
                weight1   <= clamp_weight(r_shadow[IDX_WEIGHT1]);
                weight2   <= clamp_weight(r_shadow[IDX_WEIGHT2]);
                weight3   <= clamp_weight(r_shadow[IDX_WEIGHT3]);
                bias      <= r_shadow[IDX_BIAS];
                threshold <= r_shadow[IDX_THRESHOLD];
                cfg_valid <= 1'b1;
            end
        end
    end

endmodule : perceptron_param_loader
`default_nettype wire
